// File: rtl/remove_pkt_dram_reader.sv
// DRAM block reader + shortcut merge feeding the output-queue datapath.
// Optional watchdog on stalled bursts: define DRAM_RD_WDOG_EN.
module remove_pkt_dram_reader #(
  parameter int DATA_WIDTH            = 64,
  parameter int CTRL_WIDTH            = DATA_WIDTH / 8,
  parameter int DRAM_ADDR_WIDTH       = 22,
  parameter int DRAM_DATA_WIDTH       = 2 * (DATA_WIDTH + CTRL_WIDTH),
  parameter int DRAM_BLOCK_ADDR_WIDTH = 3,
  parameter int DRAM_BLOCK_SIZE       = 128,
  parameter int DRAM_BASE_ADDR        = 0,
  parameter int FIFO_DEPTH_BITS       = 9,
  parameter int SC_AFULL_SLACK        = 8
`ifdef DRAM_RD_WDOG_EN
  , parameter int WDOG_CYCLES         = 4096
`endif
) (
  input  logic                             clk,
  input  logic                             reset_n,
  output logic [DRAM_BLOCK_ADDR_WIDTH-1:0] oq_rd_addr,
  input  logic [DRAM_BLOCK_ADDR_WIDTH-1:0] oq_wr_addr,
  input  logic [DRAM_BLOCK_ADDR_WIDTH-1:0] block_num,
  output logic                             dram_rd_req,
  output logic [DRAM_ADDR_WIDTH-1:0]       dram_rd_ptr,
  input  logic                             dram_rd_ack,
  input  logic [DRAM_DATA_WIDTH-1:0]       dram_rd_data,
  input  logic                             dram_rd_data_vld,
  input  logic                             dram_rd_done,
  input  logic [DRAM_DATA_WIDTH-1:0]       shortcut_din,
  input  logic                             shortcut_wr_en,
  output logic                             shortcut_almost_full,
  output logic                             remove_pkt_idle,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  output logic                             dram_rd_words,
  output logic                             shortcut_words,
  output logic                             output_words,
  output logic                             rd_err
);

  localparam int HW    = DATA_WIDTH + CTRL_WIDTH;
  localparam int FB    = FIFO_DEPTH_BITS;
  localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;
  localparam int BA    = DRAM_BLOCK_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_REQ  = 3'b010,
    ST_READ = 3'b100
  } state_t;

  state_t state;

  logic [DRAM_DATA_WIDTH-1:0] mem [DEPTH];
  logic [FB-1:0]              wr_ptr;
  logic [FB-1:0]              rd_ptr;
  logic [FB:0]                cnt;
  logic [FB:0]                free;
  logic                       empty;
  logic                       full;
  logic                       half_upper;

  logic                       dram_push;
  logic                       sc_push;
  logic                       sc_err;
  logic                       push;
  logic [DRAM_DATA_WIDTH-1:0] push_data;
  logic [DRAM_DATA_WIDTH-1:0] head;
  logic [HW-1:0]              half;
  logic                       is_pad;
  logic                       consume;
  logic                       pop;

  logic                       start;
  logic                       last_blk;
  logic [BA-1:0]              next_addr;
  logic [DRAM_ADDR_WIDTH-1:0] ptr_calc;
  logic                       wdog_abort;

  assign free  = (FB+1)'(DEPTH) - cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == (FB+1)'(DEPTH));

  // A DRAM beat always wins the write port over a shortcut word
  assign dram_push = state[2] && dram_rd_data_vld;
  assign sc_push   = shortcut_wr_en && !dram_push && !full;
  assign sc_err    = shortcut_wr_en && (dram_push || full);
  assign push      = dram_push || sc_push;
  assign push_data = dram_push ? dram_rd_data : shortcut_din;

  assign head    = mem[rd_ptr];
  assign half    = half_upper ? head[DRAM_DATA_WIDTH-1:HW] : head[HW-1:0];
  assign is_pad  = (half[HW-1:DATA_WIDTH] == CTRL_WIDTH'(8'h0f));
  assign consume = out_rdy && !empty;
  assign pop     = consume && !half_upper;

  assign start = state[0]
              && (block_num >= BA'(2))
              && (oq_rd_addr != oq_wr_addr)
              && (free >= (FB+1)'(DRAM_BLOCK_SIZE / 2));

  assign last_blk  = (oq_rd_addr >= block_num - BA'(1));
  assign next_addr = last_blk ? '0 : oq_rd_addr + BA'(1);
  assign ptr_calc  = DRAM_ADDR_WIDTH'(
    (32'(oq_rd_addr) + 32'(DRAM_BASE_ADDR)) * 32'(DRAM_BLOCK_SIZE));

`ifdef DRAM_RD_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_cnt;

  assign wdog_abort = (wdog_cnt == WW'(WDOG_CYCLES - 1))
                   && ((state[1] && !dram_rd_ack)
                    || (state[2] && !dram_rd_data_vld));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt <= '0;
    end else if (state[0] || dram_rd_ack || dram_rd_data_vld) begin
      wdog_cnt <= '0;
    end else begin
      wdog_cnt <= wdog_cnt + WW'(1);
    end
  end
`else
  assign wdog_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      dram_rd_req     <= 1'b0;
      dram_rd_ptr     <= '0;
      oq_rd_addr      <= '0;
      remove_pkt_idle <= 1'b0;
    end else begin
      unique case (1'b1)
        state[0]: begin
          if (start) begin
            state           <= ST_REQ;
            dram_rd_req     <= 1'b1;
            dram_rd_ptr     <= ptr_calc;
            remove_pkt_idle <= 1'b0;
          end else begin
            remove_pkt_idle <= 1'b1;
          end
        end
        state[1]: begin
          if (dram_rd_ack) begin
            state       <= ST_READ;
            dram_rd_req <= 1'b0;
          end else if (wdog_abort) begin
            state           <= ST_IDLE;
            dram_rd_req     <= 1'b0;
            remove_pkt_idle <= 1'b1;
          end
        end
        state[2]: begin
          if (dram_rd_data_vld && dram_rd_done) begin
            state           <= ST_IDLE;
            oq_rd_addr      <= next_addr;
            remove_pkt_idle <= 1'b1;
          end else if (wdog_abort) begin
            state           <= ST_IDLE;
            remove_pkt_idle <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          dram_rd_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      cnt                  <= '0;
      half_upper           <= 1'b1;
      out_wr               <= 1'b0;
      out_data             <= '0;
      out_ctrl             <= '0;
      output_words         <= 1'b0;
      dram_rd_words        <= 1'b0;
      shortcut_words       <= 1'b0;
      shortcut_almost_full <= 1'b0;
      rd_err               <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FB'(1);
      if (pop)  rd_ptr <= rd_ptr + FB'(1);
      cnt <= cnt + (FB+1)'(push) - (FB+1)'(pop);
      if (consume) half_upper <= !half_upper;
      out_wr       <= consume && !is_pad;
      output_words <= consume && !is_pad;
      if (consume && !is_pad) begin
        out_ctrl <= half[HW-1:DATA_WIDTH];
        out_data <= half[DATA_WIDTH-1:0];
      end
      dram_rd_words        <= dram_push;
      shortcut_words       <= sc_push;
      shortcut_almost_full <= (free <= (FB+1)'(SC_AFULL_SLACK));
      if (sc_err || wdog_abort) rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_remove_pkt_dram_reader.sv
// Directed + randomized bench for remove_pkt_dram_reader with a half-word queue model.
module tb_remove_pkt_dram_reader;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [2:0]   oq_rd_addr;
  logic [2:0]   oq_wr_addr;
  logic [2:0]   block_num;
  logic         dram_rd_req;
  logic [21:0]  dram_rd_ptr;
  logic         dram_rd_ack;
  logic [143:0] dram_rd_data;
  logic         dram_rd_data_vld;
  logic         dram_rd_done;
  logic [143:0] shortcut_din;
  logic         shortcut_wr_en;
  logic         shortcut_almost_full;
  logic         remove_pkt_idle;
  logic [63:0]  out_data;
  logic [7:0]   out_ctrl;
  logic         out_wr;
  logic         out_rdy;
  logic         dram_rd_words;
  logic         shortcut_words;
  logic         output_words;
  logic         rd_err;

  always #5 clk = ~clk;

  remove_pkt_dram_reader dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .oq_rd_addr           (oq_rd_addr),
    .oq_wr_addr           (oq_wr_addr),
    .block_num            (block_num),
    .dram_rd_req          (dram_rd_req),
    .dram_rd_ptr          (dram_rd_ptr),
    .dram_rd_ack          (dram_rd_ack),
    .dram_rd_data         (dram_rd_data),
    .dram_rd_data_vld     (dram_rd_data_vld),
    .dram_rd_done         (dram_rd_done),
    .shortcut_din         (shortcut_din),
    .shortcut_wr_en       (shortcut_wr_en),
    .shortcut_almost_full (shortcut_almost_full),
    .remove_pkt_idle      (remove_pkt_idle),
    .out_data             (out_data),
    .out_ctrl             (out_ctrl),
    .out_wr               (out_wr),
    .out_rdy              (out_rdy),
    .dram_rd_words        (dram_rd_words),
    .shortcut_words       (shortcut_words),
    .output_words         (output_words),
    .rd_err               (rd_err)
  );

  logic [71:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int n_out = 0;
  int n_exp = 0;
  int n_req = 0;
  int n_drw = 0;
  int n_scw = 0;
  int exp_rd = 0;
  bit rnd_rdy = 1'b0;

  task automatic chk(input string tag, input logic [143:0] obs,
                     input logic [143:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] rand_word(input bit pads);
    logic [7:0] cu;
    logic [7:0] cl;
    cu = 8'($urandom);
    cl = 8'($urandom);
    if (pads && $urandom_range(0, 3) == 0) cu = 8'h0f;
    if (pads && $urandom_range(0, 3) == 0) cl = 8'h0f;
    if (!pads && cu == 8'h0f) cu = 8'h1f;
    if (!pads && cl == 8'h0f) cl = 8'h1f;
    return {cu, 32'($urandom), 32'($urandom),
            cl, 32'($urandom), 32'($urandom)};
  endfunction

  // Each stored word yields its upper then lower half, pads dropped
  function automatic void model_push(input logic [143:0] w);
    if (w[143:136] != 8'h0f) begin
      exp_q.push_back(w[143:72]);
      n_exp++;
    end
    if (w[71:64] != 8'h0f) begin
      exp_q.push_back(w[71:0]);
      n_exp++;
    end
  endfunction

  always @(negedge clk) begin
    logic [71:0] h;
    if (dram_rd_req === 1'b1) n_req++;
    if (dram_rd_words === 1'b1) n_drw++;
    if (shortcut_words === 1'b1) n_scw++;
    if (reset_n && (out_wr || output_words))
      chk("output_words", output_words, out_wr);
    if (reset_n && out_wr === 1'b1) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("spurious_out_wr", out_wr, 1'b0);
      end else begin
        h = exp_q.pop_front();
        chk("out_word", {out_ctrl, out_data}, h);
      end
    end
  end

  always @(negedge clk) begin
    if (rnd_rdy) out_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic sc_push(input logic [143:0] w, input bit kept);
    shortcut_din   = w;
    shortcut_wr_en = 1'b1;
    if (kept) model_push(w);
    @(negedge clk);
    shortcut_wr_en = 1'b0;
  endtask

  task automatic wait_req();
    int t = 0;
    while (dram_rd_req !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("req_seen", dram_rd_req, 1'b1);
  endtask

  task automatic do_burst(input int exp_ptr, input bit pads,
                          input int collide, input bit strip, input int bn);
    logic [143:0] w;
    int d0;
    d0 = n_drw;
    wait_req();
    chk("rd_ptr", dram_rd_ptr, 144'(exp_ptr));
    repeat ($urandom_range(0, 3)) @(negedge clk);
    dram_rd_ack = 1'b1;
    @(negedge clk);
    dram_rd_ack = 1'b0;
    chk("req_drop", dram_rd_req, 1'b0);
    for (int b = 0; b < 64; b++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      w = rand_word(pads);
      if (strip && b == 0) begin
        w[143:136] = 8'h01;
        w[71:64]   = 8'h0f;
      end
      dram_rd_data     = w;
      dram_rd_data_vld = 1'b1;
      dram_rd_done     = (b == 63);
      if (b == collide) begin
        shortcut_din   = rand_word(1'b0);
        shortcut_wr_en = 1'b1;
      end
      model_push(w);
      @(negedge clk);
      dram_rd_data_vld = 1'b0;
      dram_rd_done     = 1'b0;
      shortcut_wr_en   = 1'b0;
    end
    exp_rd = (exp_rd >= bn - 1) ? 0 : exp_rd + 1;
    chk("oq_rd_addr", oq_rd_addr, 144'(exp_rd));
    @(negedge clk);
    chk("dram_rd_words", n_drw - d0, 64);
  endtask

  initial begin
    int o0;
    int e0;
    int r0;
    int s0;
    int bn;
    int nx;
    int t;
    reset_n          = 1'b0;
    oq_wr_addr       = '0;
    block_num        = '0;
    dram_rd_ack      = 1'b0;
    dram_rd_data     = '0;
    dram_rd_data_vld = 1'b0;
    dram_rd_done     = 1'b0;
    shortcut_din     = '0;
    shortcut_wr_en   = 1'b0;
    out_rdy          = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", {out_wr, out_ctrl, out_data}, 0);
    chk("rst_req", {dram_rd_req, dram_rd_ptr}, 0);
    chk("rst_addr", oq_rd_addr, 0);
    chk("rst_flags", {remove_pkt_idle, rd_err, shortcut_almost_full,
                      dram_rd_words, shortcut_words, output_words}, 0);

    reset_n   = 1'b1;
    block_num = 3'd4;
    out_rdy   = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_req", {remove_pkt_idle, dram_rd_req}, 2'b10);

    o0 = n_out;
    oq_wr_addr = 3'd1;
    do_burst(0, 1'b0, -1, 1'b0, 4);
    drain("single");
    chk("single_count", n_out - o0, 128);

    o0 = n_out;
    e0 = n_exp;
    block_num  = 3'd3;
    oq_wr_addr = 3'd0;
    do_burst(128, 1'b1, -1, 1'b1, 3);
    do_burst(256, 1'b1, -1, 1'b0, 3);
    drain("wrap");
    chk("wrap_count", n_out - o0, n_exp - e0);

    rnd_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bn = $urandom_range(2, 7);
      nx = (exp_rd >= bn - 1) ? 0 : exp_rd + 1;
      block_num  = 3'(bn);
      oq_wr_addr = 3'(nx);
      do_burst(exp_rd * 128, 1'b1, -1, 1'b0, bn);
    end
    rnd_rdy = 1'b0;
    @(negedge clk);
    out_rdy = 1'b1;
    drain("random");

    o0 = n_out;
    r0 = n_req;
    s0 = n_scw;
    for (int i = 0; i < 3; i++) sc_push(rand_word(1'b0), 1'b1);
    drain("sc");
    chk("sc_count", n_out - o0, 6);
    chk("sc_no_req", n_req - r0, 0);
    chk("sc_words", n_scw - s0, 3);
    chk("sc_idle", remove_pkt_idle, 1'b1);

    for (int i = 0; i < 4; i++) sc_push(rand_word(1'b1), 1'b1);
    out_rdy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k < 4) begin
        sc_push(rand_word(1'b1), 1'b1);
      end else begin
        @(negedge clk);
      end
      chk("bp_hold", out_wr, 1'b0);
    end
    out_rdy = 1'b1;
    drain("bp");

    out_rdy = 1'b0;
    s0 = n_scw;
    @(negedge clk);
    chk("err_pre_full", rd_err, 1'b0);
    for (int i = 0; i < 503; i++) sc_push(rand_word(1'b1), 1'b1);
    repeat (2) @(negedge clk);
    chk("afull_503", shortcut_almost_full, 1'b0);
    sc_push(rand_word(1'b1), 1'b1);
    repeat (2) @(negedge clk);
    chk("afull_504", shortcut_almost_full, 1'b1);
    for (int i = 0; i < 8; i++) sc_push(rand_word(1'b1), 1'b1);
    chk("err_at_full", rd_err, 1'b0);
    sc_push(rand_word(1'b0), 1'b0);
    chk("err_full_drop", rd_err, 1'b1);
    out_rdy = 1'b1;
    drain("full");
    chk("full_sc_words", n_scw - s0, 512);

    block_num  = 3'd7;
    oq_wr_addr = (exp_rd == 0) ? 3'd1 : 3'd0;
    wait_req();
    chk("mid_ptr", dram_rd_ptr, 144'(exp_rd * 128));
    dram_rd_ack = 1'b1;
    @(negedge clk);
    dram_rd_ack = 1'b0;
    for (int b = 0; b < 10; b++) begin
      dram_rd_data     = rand_word(1'b1);
      dram_rd_data_vld = 1'b1;
      model_push(dram_rd_data);
      @(negedge clk);
    end
    dram_rd_data = rand_word(1'b1);
    reset_n      = 1'b0;
    #1;
    chk("mid_rst_out", {out_wr, out_ctrl, out_data}, 0);
    chk("mid_rst_req", {dram_rd_req, dram_rd_ptr, oq_rd_addr}, 0);
    chk("mid_rst_flags", {remove_pkt_idle, rd_err, shortcut_almost_full,
                          dram_rd_words, shortcut_words, output_words}, 0);
    exp_q.delete();
    dram_rd_data_vld = 1'b0;
    oq_wr_addr       = 3'd0;
    block_num        = 3'd4;
    exp_rd           = 0;
    repeat (3) @(negedge clk);
    chk("rst_hold_req", dram_rd_req, 1'b0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst", {remove_pkt_idle, rd_err, oq_rd_addr}, 5'b10000);

    o0 = n_out;
    e0 = n_exp;
    oq_wr_addr = 3'd1;
    do_burst(0, 1'b1, 5, 1'b0, 4);
    chk("collide_err", rd_err, 1'b1);
    drain("collide");
    chk("collide_count", n_out - o0, n_exp - e0);

`ifdef DRAM_RD_WDOG_EN
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_req();
    t = 0;
    while (dram_rd_req === 1'b1 && t < 4200) begin
      @(negedge clk);
      t++;
    end
    chk("wdog_drop", dram_rd_req, 1'b0);
    chk("wdog_time", (t >= 4090 && t <= 4100), 1'b1);
    chk("wdog_err", rd_err, 1'b1);
    chk("wdog_addr", oq_rd_addr, 0);
    oq_wr_addr = 3'd0;
    reset_n = 1'b0;
    @(negedge clk);
`else
    t = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
